// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is captured on a load
// strobe while idle, then sent one bit per accepted beat over a valid/ready
// serial handshake. A one-cycle done pulse follows the final beat, and a new
// word can be loaded in that same cycle.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   LSB_FIRST  1 = bit 0 leaves first, 0 = bit WIDTH-1 leaves first
//
// Optional build macro:
//   PISO_PARITY_EN  when defined, an even-parity bit (XOR of the word) is sent
//                   as an extra beat after the last data bit.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   en       in   load strobe, taken only when ready is high
//   d        in   parallel word to load
//   ready    out  idle and able to accept a load
//   q        out  current serial bit
//   q_valid  out  q holds a valid bit
//   q_ready  in   downstream accepts the bit this cycle
//   done     out  one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic             ready,
    output logic             q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] PAR   = 2'd2;
`endif

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shiftReg;
    logic [CNT_W-1:0] r_bitCnt;
    logic             r_done;
`ifdef PISO_PARITY_EN
    logic             r_parity;
`endif

    logic             w_beat;
    logic             w_lastBit;
    logic             w_dataBit;
    logic [WIDTH-1:0] w_shifted;

    // The outgoing bit always sits at the output end of the shift register,
    // and each beat moves the next bit into that position with zero fill.
    assign w_dataBit = (LSB_FIRST != 0) ? r_shiftReg[0] : r_shiftReg[WIDTH-1];
    assign w_shifted = (LSB_FIRST != 0) ? {1'b0, r_shiftReg[WIDTH-1:1]}
                                        : {r_shiftReg[WIDTH-2:0], 1'b0};

    assign w_beat    = q_valid && q_ready;
    assign w_lastBit = (r_bitCnt == LAST_CNT);

    assign ready = (r_state == IDLE);
    assign done  = r_done;

`ifdef PISO_PARITY_EN
    assign q_valid = (r_state == SHIFT) || (r_state == PAR);
    assign q       = (r_state == PAR) ? r_parity : w_dataBit;
`else
    assign q_valid = (r_state == SHIFT);
    assign q       = w_dataBit;
`endif

    // Main sequencer. q and q_valid are decoded from held state, so they stay
    // stable for as long as the consumer stalls. The counter is held on the
    // final beat instead of incrementing so it never wraps within a word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
            r_done     <= 1'b0;
`ifdef PISO_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_shiftReg <= d;
                        r_bitCnt   <= '0;
                        r_state    <= SHIFT;
`ifdef PISO_PARITY_EN
                        r_parity   <= ^d;
`endif
                    end
                end
                SHIFT: begin
                    if (w_beat) begin
                        r_shiftReg <= w_shifted;
                        if (w_lastBit) begin
`ifdef PISO_PARITY_EN
                            r_state <= PAR;
`else
                            r_state <= IDLE;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end
                end
`ifdef PISO_PARITY_EN
                PAR: begin
                    if (w_beat) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Drives two serializers (LSB-first and MSB-first) from the same stimulus.
// Every accepted load pushes the expected beats of the word into a scoreboard
// queue; the monitor pops one entry per accepted beat and compares both serial
// outputs, and also checks ready, q_valid, done and stall stability each cycle.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W = 8;

    typedef struct {
        logic lsbBit;
        logic msbBit;
        logic last;
    } beat_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] d;
    logic         q_ready;

    logic readyL, qL, qValidL, doneL;
    logic readyM, qM, qValidM, doneM;

    beat_t sb[$];
    beat_t item;
    beat_t pushItem;

    int   checkCount = 0;
    int   passCount  = 0;
    bit   checkEn    = 0;
    bit   pendingDone = 0;
    bit   nextPending;
    bit   modelBusy;
    bit   prevStall = 0;
    logic prevQL, prevQM;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) dutLsb (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d),
        .ready(readyL), .q(qL), .q_valid(qValidL),
        .q_ready(q_ready), .done(doneL)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) dutMsb (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d),
        .ready(readyM), .q(qM), .q_valid(qValidM),
        .q_ready(q_ready), .done(doneM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && readyL !== 1'b1; i++) cyc(1);
    endtask

    task automatic applyStimulus(input logic [W-1:0] data);
        en = 1'b1;
        d  = data;
        cyc(1);
        en = 1'b0;
    endtask

    // Scoreboard monitor, sampled on the falling edge. Inputs are stable here,
    // so the cycle's outcome at the next rising edge is already known: a beat
    // happens when a bit is outstanding and q_ready is high, and a load is
    // taken when nothing is outstanding and en is high.
    always @(negedge clk) begin
        if (checkEn) begin
            modelBusy = (sb.size() != 0);
            checkOutput("readyLsb",  readyL,  !modelBusy);
            checkOutput("readyMsb",  readyM,  !modelBusy);
            checkOutput("validLsb",  qValidL, modelBusy);
            checkOutput("validMsb",  qValidM, modelBusy);
            checkOutput("doneLsb",   doneL,   pendingDone);
            checkOutput("doneMsb",   doneM,   pendingDone);
            if (prevStall) begin
                checkOutput("stallLsb", qL, prevQL);
                checkOutput("stallMsb", qM, prevQM);
            end
            nextPending = 1'b0;
            if (rst_n && modelBusy && q_ready) begin
                item = sb.pop_front();
                checkOutput("bitLsb", qL, item.lsbBit);
                checkOutput("bitMsb", qM, item.msbBit);
                nextPending = item.last;
            end
            prevStall = rst_n && modelBusy && !q_ready;
            prevQL    = qL;
            prevQM    = qM;
            if (!rst_n) begin
                sb.delete();
                pendingDone = 1'b0;
                prevStall   = 1'b0;
            end else begin
                pendingDone = nextPending;
                if (!modelBusy && en) begin
                    for (int i = 0; i < W; i++) begin
                        pushItem.lsbBit = d[i];
                        pushItem.msbBit = d[W-1-i];
`ifdef PISO_PARITY_EN
                        pushItem.last   = 1'b0;
`else
                        pushItem.last   = (i == W - 1);
`endif
                        sb.push_back(pushItem);
                    end
`ifdef PISO_PARITY_EN
                    pushItem.lsbBit = ^d;
                    pushItem.msbBit = ^d;
                    pushItem.last   = 1'b1;
                    sb.push_back(pushItem);
`endif
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        d       = '0;
        q_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("resetQLsb", qL, 1'b0);
        checkOutput("resetQMsb", qM, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1);

        // Plain words at full rate, including parity-relevant patterns.
        waitIdle(); applyStimulus(8'hA5); cyc(12);
        waitIdle(); applyStimulus(8'h0F); cyc(12);
        waitIdle(); applyStimulus(8'h07); cyc(12);

        // Backpressure held for three cycles while bit 2 is presented.
        waitIdle(); applyStimulus(8'h3C);
        cyc(2);
        q_ready = 1'b0;
        cyc(3);
        q_ready = 1'b1;
        cyc(12);

        // Load attempt while busy, then a load landing in the done cycle.
        waitIdle(); applyStimulus(8'h00);
        cyc(3);
        d = 8'hFF; en = 1'b1;
        cyc(1);
        en = 1'b0;
        cyc(2);
        d = 8'h81; en = 1'b1;
        cyc(3);
        en = 1'b0;
        cyc(12);

        // Reset after three beats aborts the word.
        waitIdle(); applyStimulus(8'h5A);
        cyc(3);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        applyStimulus(8'h01);
        cyc(12);

        // Randomized traffic with occasional resets.
        repeat (400) begin
            en      = ($urandom_range(0, 3) == 0);
            d       = W'($urandom);
            q_ready = ($urandom_range(0, 3) != 0);
            rst_n   = ($urandom_range(0, 99) != 0);
            cyc(1);
        end
        rst_n   = 1'b1;
        en      = 1'b0;
        q_ready = 1'b1;
        for (int i = 0; i < 100 && (sb.size() != 0 || pendingDone); i++) cyc(1);
        cyc(2);
        checkOutput("drainEmpty", (sb.size() == 0), 1);

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
